lsu_riscv: RTL
==============

# lsu_riscv

Load/store unit sitting directly downstream of the instruction decoder in the single-cycle RISC-V core. Consumes the decoder's memory-request, write-enable and access-size controls plus the ALU-computed address and rs2 data. Runs a request/grant/response handshake with the data memory, stalling the core until the access completes. Aligns store data into byte lanes and extracts/extends load data for register write-back.

## Interface
- No parameters; address and data widths fixed at 32.
- clk_i  in  1  core clock
- rst_n_i  in  1  reset; asynchronous assert, active-low
- lsu_req_i  in  1  memory access requested (decoder mem_req)
- lsu_we_i  in  1  1 = store, 0 = load (decoder mem_we)
- lsu_size_i  in  3  access size, LDST_B/H/W/BU/HU encodings (decoder mem_size)
- lsu_addr_i  in  32  byte address (ALU result)
- lsu_data_i  in  32  store data (rs2)
- lsu_data_o  out  32  extended load data for write-back
- lsu_stall_req_o  out  1  hold PC/pipeline while high
- lsu_misaligned_o  out  1  misaligned access flag (only with LSU_MISALIGN_CHECK_EN)
- data_req_o  out  1  memory request
- data_we_o  out  1  memory write
- data_be_o  out  4  byte enables
- data_addr_o  out  32  word address, {lsu_addr_i[31:2],2'b00}
- data_wdata_o  out  32  lane-replicated store data
- data_gnt_i  in  1  memory accepted request this cycle
- data_rvalid_i  in  1  read data valid this cycle
- data_rdata_i  in  32  read data

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
- IDLE: lsu_req_i with a valid size -> data_req_o=1 same cycle. gnt && store -> stay IDLE, access done. gnt && load -> WAIT_RVALID, capturing size and addr[1:0]. No gnt -> WAIT_GNT.
- WAIT_GNT: data_req_o held at 1 with stable addr/we/be/wdata (core stalled, inputs stable). gnt -> as from IDLE.
- WAIT_RVALID: data_req_o=0; rvalid -> IDLE, load done.
- lsu_stall_req_o = lsu_req_i && !done; done = store granted this cycle, or rvalid in WAIT_RVALID.
- Byte enables: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<{addr[1],1'b0}; W 4'b1111.
- Store data: B byte replicated ×4; H halfword replicated ×2; W unchanged.
- Load extract by captured offset: LB/LBU byte lane sign/zero-extended; LH/LHU halfword at addr[1] sign/zero-extended; LW whole word.
- Invalid size (3'b011, 3'b110, 3'b111): no data_req_o, no stall, lsu_data_o=0.
- lsu_data_o valid only in the rvalid cycle; 0 otherwise.
- data_we_o/data_be_o/data_wdata_o forced 0 whenever data_req_o=0.

## Timing
- Reset: state IDLE; every output 0 while rst_n_i low, regardless of inputs. Reset mid-access abandons it; a later rvalid in IDLE is ignored.
- Store latency: 0 extra cycles if gnt in request cycle; otherwise stall until gnt cycle inclusive-low (stall drops in gnt cycle).
- Load latency: minimum 1 stall cycle (rvalid no earlier than cycle after gnt); stall drops in rvalid cycle, write-back on that edge.
- Memory must not assert gnt and rvalid for the same request in one cycle; rvalid outside WAIT_RVALID ignored.
- lsu_req_i dropping in WAIT_GNT: request withdrawn, return to IDLE. In WAIT_RVALID: state held until rvalid.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 -> lsu_misaligned_o=1 combinationally, no data_req_o, no stall, lsu_data_o=0.
- Undefined: port lsu_misaligned_o absent; low address bits beyond lane selection ignored (H uses addr[1], W uses word), access proceeds.

## Structure
- Shared package riscv_pkg: LDST_B/H/W/BU/HU constants, lsu state enum type.
- One sub-module: lsu_load_ext (combinational lane select + sign/zero extension from size, offset, rdata).

## Test plan
- SB x=0xAABBCCDD at addr 0x102, gnt same cycle -> be=4'b0100, wdata=0xDDDDDDDD, addr=0x100, no stall.
- LB addr 0x103, rdata 0x80123456, gnt cycle 0, rvalid cycle 2 -> stall cycles 0-1, lsu_data_o=0xFFFFFF80 in cycle 2.
- LHU addr 0x202, rdata 0xBEEF1234 -> lsu_data_o=0x0000BEEF; LH same -> 0xFFFFBEEF.
- SW with gnt delayed 3 cycles -> data_req_o and outputs stable 4 cycles, stall low only in gnt cycle.
- Reset asserted in WAIT_RVALID, rvalid arrives after release -> outputs 0, no data on lsu_data_o, state IDLE.
- With LSU_MISALIGN_CHECK_EN: LW addr 0x101 -> lsu_misaligned_o=1, data_req_o=0, stall=0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared definitions for the RISC-V load/store path. Holds the
//               decoder access-size encodings (funct3 style), the LSU state
//               type and a helper that flags legal access sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE        = 2'd0,
    LSU_WAIT_GNT    = 2'd1,
    LSU_WAIT_RVALID = 2'd2
  } lsu_state_e;

  // 3'b011, 3'b110 and 3'b111 are not load/store sizes.
  function automatic logic size_valid(input logic [2:0] size);
    case (size)
      LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU: size_valid = 1'b1;
      default:                                  size_valid = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_ext
// Description : Combinational load-data lane select and sign/zero extension.
// Ports       : size   - captured access size (LDST_* encoding)
//               offset - captured byte offset addr[1:0]
//               rdata  - raw word returned by data memory
//               data   - extended value for register write-back
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_ext
  import riscv_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      LDST_B:  data = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: data = {24'd0, byte_sel};
      LDST_H:  data = {{16{half_sel[15]}}, half_sel};
      LDST_HU: data = {16'd0, half_sel};
      LDST_W:  data = rdata;
      default: data = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_riscv.sv
`default_nettype none
// ============================================================================
// Module      : lsu_riscv
// Description : Load/store unit for the single-cycle RISC-V core. Runs the
//               req/gnt/rvalid handshake with data memory, stalls the core
//               until the access completes, lane-aligns store data and
//               extracts/extends load data.
// Ports       : clk_i, rst_n_i (async active-low)
//               lsu_req_i/lsu_we_i/lsu_size_i/lsu_addr_i/lsu_data_i - core side
//               lsu_data_o, lsu_stall_req_o, lsu_misaligned_o   - core side
//               data_req_o/we/be/addr/wdata, data_gnt_i,
//               data_rvalid_i, data_rdata_i                     - memory side
// Config      : LSU_MISALIGN_CHECK_EN - when defined, misaligned H/HU/W accesses
//               are flagged on lsu_misaligned_o and suppressed.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_riscv
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
`ifdef LSU_MISALIGN_CHECK_EN
  output logic        lsu_misaligned_o,
`endif
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  lsu_state_e  state;
  logic [2:0]  ld_size;
  logic [1:0]  ld_off;

  logic        misaligned;
  logic        access_ok;
  logic        issuing;
  logic        store_done;
  logic        load_done;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ext_data;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = lsu_req_i && size_valid(lsu_size_i) &&
                      ((((lsu_size_i == LDST_H) || (lsu_size_i == LDST_HU)) && lsu_addr_i[0]) ||
                       ((lsu_size_i == LDST_W) && (lsu_addr_i[1:0] != 2'b00)));
  assign lsu_misaligned_o = rst_n_i && misaligned && (state != LSU_WAIT_RVALID);
`else
  assign misaligned = 1'b0;
`endif

  assign access_ok  = lsu_req_i && size_valid(lsu_size_i) && !misaligned;
  // Request is driven combinationally in IDLE and held in WAIT_GNT; the
  // reset term keeps every output low while rst_n_i is asserted.
  assign issuing    = rst_n_i && access_ok && (state != LSU_WAIT_RVALID);
  assign store_done = issuing && data_gnt_i && lsu_we_i;
  assign load_done  = rst_n_i && (state == LSU_WAIT_RVALID) && data_rvalid_i;

  always_comb begin
    be    = 4'b1111;
    wdata = lsu_data_i;
    case (lsu_size_i)
      LDST_B, LDST_BU: begin
        be    = 4'b0001 << lsu_addr_i[1:0];
        wdata = {4{lsu_data_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        be    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata = {2{lsu_data_i[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = lsu_data_i;
      end
    endcase
  end

  assign data_req_o      = issuing;
  assign data_we_o       = issuing && lsu_we_i;
  assign data_be_o       = issuing ? be : 4'd0;
  assign data_addr_o     = issuing ? {lsu_addr_i[31:2], 2'b00} : 32'd0;
  assign data_wdata_o    = (issuing && lsu_we_i) ? wdata : 32'd0;

  assign lsu_stall_req_o = rst_n_i && lsu_req_i &&
                           ((issuing && !store_done) ||
                            ((state == LSU_WAIT_RVALID) && !data_rvalid_i));

  lsu_load_ext u_load_ext (
    .size   (ld_size),
    .offset (ld_off),
    .rdata  (data_rdata_i),
    .data   (ext_data)
  );

  assign lsu_data_o = load_done ? ext_data : 32'd0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= LSU_IDLE;
      ld_size <= LDST_W;
      ld_off  <= 2'd0;
    end else begin
      case (state)
        LSU_IDLE, LSU_WAIT_GNT: begin
          if (access_ok) begin
            if (data_gnt_i) begin
              if (lsu_we_i) begin
                state <= LSU_IDLE;
              end else begin
                state   <= LSU_WAIT_RVALID;
                ld_size <= lsu_size_i;
                ld_off  <= lsu_addr_i[1:0];
              end
            end else begin
              state <= LSU_WAIT_GNT;
            end
          end else begin
            // No request (or withdrawn while waiting for grant).
            state <= LSU_IDLE;
          end
        end
        LSU_WAIT_RVALID: begin
          if (data_rvalid_i) state <= LSU_IDLE;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
